// File: rtl/pulse_sync_arb_pkg.sv
// pulse_sync_arb_pkg
//   Shared types and helpers for the pulse_sync_arb slice.
//   - src_state_t : source-side handshake FSM encoding
//   - id_width()  : requester-ID width for a given requester count
//   - wrap_inc()  : increment with wrap at n (round-robin pointer advance)
package pulse_sync_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } src_state_t;

    function automatic int id_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return ((v + 1) >= n) ? 0 : (v + 1);
    endfunction

endpackage

// File: rtl/pulse_rr_arb.sv
// pulse_rr_arb
//   Combinational arbiter over N_REQ pending requests.
//   Default build: round-robin, highest priority at rr_ptr, search upward with wrap.
//   With PULSE_SYNC_ARB_FIXED_PRI_EN defined: fixed priority, lowest index wins,
//   rr_ptr is ignored.
//   Ports:
//     req      : pending request vector
//     rr_ptr   : round-robin start index
//     grant    : one-hot grant (all zero when req is zero)
//     grant_id : encoded index of the granted requester
module pulse_rr_arb
    import pulse_sync_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    localparam int unsigned N = N_REQ;

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned k = 0; k < N; k++) begin
`ifdef PULSE_SYNC_ARB_FIXED_PRI_EN
            idx = ID_W'(k);
`else
            idx = ID_W'((32'(rr_ptr) + k) % N);
`endif
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/sync.sv
// sync
//   Multi-flop synchronizer cell. Two stages, plus a third when DELAY_2 != 0.
//   Ports:
//     clk   : destination clock
//     rst_n : async active-low reset, loads DATA_DEFAULT into every stage
//     d     : asynchronous input
//     q     : synchronized output
module sync #(
    parameter int                  D_WIDTH      = 1,
    parameter logic [D_WIDTH-1:0]  DATA_DEFAULT = '0,
    parameter int                  DELAY_2      = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [D_WIDTH-1:0] d,
    output logic [D_WIDTH-1:0] q
);

    localparam int unsigned STAGES = (DELAY_2 != 0) ? 3 : 2;

    logic [D_WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) stage[i] <= DATA_DEFAULT;
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/pulse_sync_arb.sv
// pulse_sync_arb
//   Shares one 4-phase req/ack CDC channel (src_clk -> dst_clk) among N_REQ
//   pulse requesters. Pulses are captured as pending bits, granted by
//   pulse_rr_arb, and each grant is re-emitted as a one-cycle dst_pulse bit.
//   Optional macro PULSE_SYNC_ARB_FIXED_PRI_EN selects fixed priority
//   (lowest index wins, no rr_ptr register); port list is unchanged.
//   Ports:
//     src_clk, src_rst_n : source clock, async active-low reset
//     dst_clk, dst_rst_n : destination clock, async active-low reset
//     src_pulse          : one-cycle event per requester (src_clk)
//     src_pend           : event captured, not yet launched
//     src_drop           : one-cycle flag, event coalesced into a pending one
//     src_busy           : handshake in flight
//     dst_pulse          : one-hot one-cycle pulse per delivered event (dst_clk)
module pulse_sync_arb
    import pulse_sync_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = id_width(N_REQ),
    parameter int DELAY_2 = 1
) (
    input  logic             src_clk,
    input  logic             src_rst_n,
    input  logic             dst_clk,
    input  logic             dst_rst_n,
    input  logic [N_REQ-1:0] src_pulse,
    output logic [N_REQ-1:0] src_pend,
    output logic [N_REQ-1:0] src_drop,
    output logic             src_busy,
    output logic [N_REQ-1:0] dst_pulse
);

    // ---------------- source domain ----------------
    src_state_t       state, state_nxt;
    logic [N_REQ-1:0] pend, pend_nxt, pend_clr;
    logic [N_REQ-1:0] drop, drop_nxt;
    logic             req, req_nxt;
    logic [ID_W-1:0]  id_reg, id_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             ack_s;

    // ---------------- destination domain ----------------
    logic             req_d;
    logic             ack;
    logic [N_REQ-1:0] dst_pulse_r;

    pulse_rr_arb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req      (pend),
        .rr_ptr   (rr_ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    sync #(
        .D_WIDTH      (1),
        .DATA_DEFAULT (1'b0),
        .DELAY_2      (DELAY_2)
    ) u_ack_sync (
        .clk   (src_clk),
        .rst_n (src_rst_n),
        .d     (ack),
        .q     (ack_s)
    );

    always_comb begin
        state_nxt = state;
        req_nxt   = req;
        id_nxt    = id_reg;
        pend_clr  = '0;
        unique case (state)
            IDLE: begin
                if (|pend) begin
                    pend_clr  = grant;
                    id_nxt    = grant_id;
                    req_nxt   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A pulse arriving as its bit is granted re-arms the bit rather than dropping.
        pend_nxt = (pend & ~pend_clr) | src_pulse;
        drop_nxt = src_pulse & pend & ~pend_clr;
    end

    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            state  <= IDLE;
            pend   <= '0;
            drop   <= '0;
            req    <= 1'b0;
            id_reg <= '0;
        end else begin
            state  <= state_nxt;
            pend   <= pend_nxt;
            drop   <= drop_nxt;
            req    <= req_nxt;
            id_reg <= id_nxt;
        end
    end

`ifdef PULSE_SYNC_ARB_FIXED_PRI_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            rr_ptr <= '0;
        end else if (state == IDLE && |pend) begin
            rr_ptr <= ID_W'(wrap_inc(32'(grant_id), N_REQ));
        end
    end
`endif

    // id_reg is held while req or ack_s is high, so it is stable when sampled here.
    sync #(
        .D_WIDTH      (1),
        .DATA_DEFAULT (1'b0),
        .DELAY_2      (DELAY_2)
    ) u_req_sync (
        .clk   (dst_clk),
        .rst_n (dst_rst_n),
        .d     (req),
        .q     (req_d)
    );

    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            ack         <= 1'b0;
            dst_pulse_r <= '0;
        end else begin
            ack         <= req_d;
            dst_pulse_r <= (req_d && !ack) ? (N_REQ'(1) << id_reg) : '0;
        end
    end

    assign src_pend  = pend;
    assign src_drop  = drop;
    assign src_busy  = (state != IDLE);
    assign dst_pulse = dst_pulse_r;

endmodule

// File: tb/tb_pulse_sync_arb.sv
module tb_pulse_sync_arb;

    localparam int N_REQ   = 4;
    localparam int DELAY_2 = 1;
    localparam int LAT     = 2 + DELAY_2 + 1;

    logic             src_clk;
    logic             src_rst_n;
    logic             dst_clk;
    logic             dst_rst_n;
    logic [N_REQ-1:0] src_pulse;
    logic [N_REQ-1:0] src_pend;
    logic [N_REQ-1:0] src_drop;
    logic             src_busy;
    logic [N_REQ-1:0] dst_pulse;

    int n_tests;
    int n_fail;
    int drop_cnt;
    int onehot_bad;
    logic [N_REQ-1:0] log_q [$];

    pulse_sync_arb #(
        .N_REQ   (N_REQ),
        .ID_W    (2),
        .DELAY_2 (DELAY_2)
    ) dut (
        .src_clk   (src_clk),
        .src_rst_n (src_rst_n),
        .dst_clk   (dst_clk),
        .dst_rst_n (dst_rst_n),
        .src_pulse (src_pulse),
        .src_pend  (src_pend),
        .src_drop  (src_drop),
        .src_busy  (src_busy),
        .dst_pulse (dst_pulse)
    );

    // src edges at 5+10k, dst edges at 20+40k: never coincident
    initial begin
        src_clk = 1'b0;
        forever #5 src_clk = ~src_clk;
    end
    initial begin
        dst_clk = 1'b0;
        forever #20 dst_clk = ~dst_clk;
    end

    always @(posedge dst_clk) begin
        #1;
        if (dst_pulse != '0) begin
            log_q.push_back(dst_pulse);
            if (!$onehot(dst_pulse)) onehot_bad++;
        end
    end

    always @(posedge src_clk) begin
        #1;
        if (src_drop != '0) drop_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic src_tick();
        @(posedge src_clk);
        #1;
    endtask

    task automatic pulse(input logic [N_REQ-1:0] v);
        src_pulse = v;
        src_tick();
        src_pulse = '0;
    endtask

    task automatic do_reset(input bit check_vals);
        src_rst_n = 1'b0;
        dst_rst_n = 1'b0;
        src_pulse = '0;
        repeat (3) @(posedge dst_clk);
        #1;
        if (check_vals) begin
            check("rst_pend", 32'(src_pend), 32'h0);
            check("rst_drop", 32'(src_drop), 32'h0);
            check("rst_busy", 32'(src_busy), 32'h0);
            check("rst_dst_pulse", 32'(dst_pulse), 32'h0);
        end
        src_rst_n = 1'b1;
        dst_rst_n = 1'b1;
        src_tick();
        log_q.delete();
        drop_cnt = 0;
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            src_tick();
            if (!src_busy && src_pend == '0) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, 32'(done), 32'h1);
        repeat (5) @(posedge dst_clk);
        #1;
    endtask

    initial begin
        int n;
        bit seen;
        n_tests    = 0;
        n_fail     = 0;
        drop_cnt   = 0;
        onehot_bad = 0;
        src_pulse  = '0;
        src_rst_n  = 1'b0;
        dst_rst_n  = 1'b0;

        // ---- 1: single event, latency, busy returns low ----
        do_reset(1'b1);
        pulse(4'b0100);
        check("t1_pend", 32'(src_pend), 32'h4);
        check("t1_busy_before", 32'(src_busy), 32'h0);
        src_tick();
        check("t1_busy_launch", 32'(src_busy), 32'h1);
        check("t1_pend_cleared", 32'(src_pend), 32'h0);
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge dst_clk);
            #1;
            n++;
            if (dst_pulse != '0) begin
                seen = 1'b1;
                break;
            end
        end
        check("t1_seen", 32'(seen), 32'h1);
        check("t1_latency", 32'(n), 32'(LAT));
        check("t1_dst_pulse", 32'(dst_pulse), 32'h4);
        for (int i = 0; i < 300; i++) begin
            if (!src_busy) break;
            src_tick();
        end
        check("t1_busy_done", 32'(src_busy), 32'h0);
        repeat (5) @(posedge dst_clk);
        #1;
        check("t1_count", 32'(log_q.size()), 32'h1);

        // ---- 2: all four at once, RR order from reset ----
        do_reset(1'b0);
        pulse(4'b1111);
        check("t2_pend", 32'(src_pend), 32'hF);
        drain("t2_drain");
        check("t2_count", 32'(log_q.size()), 32'h4);
        check("t2_ev0", 32'(log_q[0]), 32'h1);
        check("t2_ev1", 32'(log_q[1]), 32'h2);
        check("t2_ev2", 32'(log_q[2]), 32'h4);
        check("t2_ev3", 32'(log_q[3]), 32'h8);
        check("t2_no_drop", 32'(drop_cnt), 32'h0);

        // ---- 3: coalescing while in flight ----
        do_reset(1'b0);
        pulse(4'b0010);
        src_tick();
        check("t3_busy", 32'(src_busy), 32'h1);
        pulse(4'b0010);
        check("t3_pend_rearm", 32'(src_pend), 32'h2);
        check("t3_no_drop_yet", 32'(src_drop), 32'h0);
        pulse(4'b0010);
        check("t3_drop", 32'(src_drop), 32'h2);
        check("t3_pend_hold", 32'(src_pend), 32'h2);
        src_tick();
        check("t3_drop_one_cycle", 32'(src_drop), 32'h0);
        drain("t3_drain");
        check("t3_drop_cnt", 32'(drop_cnt), 32'h1);
        check("t3_count", 32'(log_q.size()), 32'h2);
        check("t3_ev0", 32'(log_q[0]), 32'h2);
        check("t3_ev1", 32'(log_q[1]), 32'h2);

        // ---- 4: rr_ptr=2 (after granting 1) with pend=1011 ----
        do_reset(1'b0);
        pulse(4'b0010);
        src_tick();
        pulse(4'b1011);
        check("t4_pend", 32'(src_pend), 32'hB);
        drain("t4_drain");
        check("t4_count", 32'(log_q.size()), 32'h4);
        check("t4_ev0", 32'(log_q[0]), 32'h2);
`ifdef PULSE_SYNC_ARB_FIXED_PRI_EN
        check("t4_ev1", 32'(log_q[1]), 32'h1);
        check("t4_ev2", 32'(log_q[2]), 32'h2);
        check("t4_ev3", 32'(log_q[3]), 32'h8);
`else
        check("t4_ev1", 32'(log_q[1]), 32'h8);
        check("t4_ev2", 32'(log_q[2]), 32'h1);
        check("t4_ev3", 32'(log_q[3]), 32'h2);
`endif

        // ---- 5: dst reset while src in REQ ----
        do_reset(1'b0);
        pulse(4'b0001);
        src_tick();
        check("t5_busy", 32'(src_busy), 32'h1);
        dst_rst_n = 1'b0;
        repeat (10) @(posedge dst_clk);
        #1;
        check("t5_no_pulse_in_rst", 32'(log_q.size()), 32'h0);
        check("t5_busy_held", 32'(src_busy), 32'h1);
        dst_rst_n = 1'b1;
        drain("t5_drain");
        check("t5_count", 32'(log_q.size()), 32'h1);
        check("t5_ev0", 32'(log_q[0]), 32'h1);

        // ---- 6: src reset before dst sees req ----
        do_reset(1'b0);
        pulse(4'b1000);
        src_tick();
        check("t6_busy", 32'(src_busy), 32'h1);
        src_rst_n = 1'b0;
        #1;
        check("t6_rst_pend", 32'(src_pend), 32'h0);
        check("t6_rst_busy", 32'(src_busy), 32'h0);
        check("t6_rst_drop", 32'(src_drop), 32'h0);
        repeat (2) src_tick();
        src_rst_n = 1'b1;
        repeat (12) @(posedge dst_clk);
        #1;
        check("t6_no_pulse", 32'(log_q.size()), 32'h0);
        src_tick();
        pulse(4'b0100);
        check("t6_new_pend", 32'(src_pend), 32'h4);
        drain("t6_drain");
        check("t6_count", 32'(log_q.size()), 32'h1);
        check("t6_ev0", 32'(log_q[0]), 32'h4);

        check("onehot", 32'(onehot_bad), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
